// File: rtl/battle_controller_if.sv
// Bundle of all fight request, stat lookup and outcome signals between the
// interaction logic (master) and battle_controller (slave).
// Latency: n/a (wires only).  Backpressure: none; start is only honoured while idle.
// Ports: start/enemy_tile/player stats in, lookup_tile_id out, enemy_*_in lookup
//        results in, busy/done/result/hp/hit/round status out.
interface battle_controller_if;
  logic        start;
  logic [15:0] enemy_tile;
  logic [15:0] player_hp_in;
  logic [15:0] player_atk;
  logic [15:0] player_def;
  logic [15:0] lookup_tile_id;
  logic [15:0] enemy_atk_in;
  logic [15:0] enemy_def_in;
  logic [15:0] enemy_hp_in;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [15:0] player_hp_out;
  logic [15:0] enemy_hp_out;
  logic        hit_strobe;
  logic        hit_side;
  logic [7:0]  round_cnt;

  // Interaction logic side: issues fights and answers the stat lookups.
  modport master (
    output start, enemy_tile, player_hp_in, player_atk, player_def,
    output enemy_atk_in, enemy_def_in, enemy_hp_in,
    input  lookup_tile_id, busy, done, result, player_hp_out, enemy_hp_out,
    input  hit_strobe, hit_side, round_cnt
  );

  // Controller side.
  modport slave (
    input  start, enemy_tile, player_hp_in, player_atk, player_def,
    input  enemy_atk_in, enemy_def_in, enemy_hp_in,
    output lookup_tile_id, busy, done, result, player_hp_out, enemy_hp_out,
    output hit_strobe, hit_side, round_cnt
  );
endinterface

// File: rtl/battle_controller.sv
// Runs one player-vs-enemy fight: latch tile/stats, then paced alternating strikes.
// Latency: done 3 cycles after start when refused, else 3 + strikes*ROUND_CYCLES.
// Backpressure: start is ignored while busy (any state other than IDLE).
// Ports: clk, rst_n (async active-low), bus (battle_controller_if.slave).
module battle_controller #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  battle_controller_if.slave    bus
);

  localparam int PW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [PW-1:0] PACE_LAST = PW'(ROUND_CYCLES - 1);

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_WIN     = 2'd1;
  localparam logic [1:0] RES_LOSE    = 2'd2;
  localparam logic [1:0] RES_REFUSED = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, P_HIT, E_HIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pace;
  logic [15:0]   p_atk, p_def, e_atk, e_def;

  // Player damage is only used after CHECK proved p_atk > e_def, so it never wraps.
  logic [15:0] p_dmg, e_dmg;
  assign p_dmg = p_atk - e_def;
  assign e_dmg = (e_atk > p_def) ? (e_atk - p_def) : 16'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pace               <= '0;
      p_atk              <= '0;
      p_def              <= '0;
      e_atk              <= '0;
      e_def              <= '0;
      bus.lookup_tile_id <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.result         <= RES_NONE;
      bus.player_hp_out  <= '0;
      bus.enemy_hp_out   <= '0;
      bus.hit_strobe     <= 1'b0;
      bus.hit_side       <= 1'b0;
      bus.round_cnt      <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.hit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.lookup_tile_id <= bus.enemy_tile;
            bus.player_hp_out  <= bus.player_hp_in;
            p_atk              <= bus.player_atk;
            p_def              <= bus.player_def;
            bus.result         <= RES_NONE;
            bus.round_cnt      <= '0;
            pace               <= '0;
            bus.busy           <= 1'b1;
            state              <= LOAD;
          end
        end
        LOAD: begin
          // Lookups have had a full cycle to settle on the latched tile id.
          e_atk            <= bus.enemy_atk_in;
          e_def            <= bus.enemy_def_in;
          bus.enemy_hp_out <= bus.enemy_hp_in;
          pace             <= '0;
          state            <= CHECK;
        end
        CHECK: begin
          pace <= '0;
          if (p_atk <= e_def) begin
            bus.result <= RES_REFUSED;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            state <= P_HIT;
          end
        end
        P_HIT: begin
          if (pace == PACE_LAST) begin
            pace           <= '0;
            bus.hit_strobe <= 1'b1;
            bus.hit_side   <= 1'b0;
            if (bus.round_cnt != 8'hFF) bus.round_cnt <= bus.round_cnt + 8'd1;
            if (p_dmg >= bus.enemy_hp_out) begin
              bus.enemy_hp_out <= '0;
              bus.result       <= RES_WIN;
              bus.done         <= 1'b1;
              state            <= DONE;
            end else begin
              bus.enemy_hp_out <= bus.enemy_hp_out - p_dmg;
              state            <= E_HIT;
            end
          end else begin
            pace <= pace + 1'b1;
          end
        end
        E_HIT: begin
          if (pace == PACE_LAST) begin
            pace           <= '0;
            bus.hit_strobe <= 1'b1;
            bus.hit_side   <= 1'b1;
            // A zero-damage strike never kills, even a player already at 0 hp.
            if ((e_dmg != 16'd0) && (e_dmg >= bus.player_hp_out)) begin
              bus.player_hp_out <= '0;
              bus.result        <= RES_LOSE;
              bus.done          <= 1'b1;
              state             <= DONE;
            end else begin
              bus.player_hp_out <= bus.player_hp_out - e_dmg;
              state             <= P_HIT;
            end
          end else begin
            pace <= pace + 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          pace     <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_battle_controller.sv
module tb_battle_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  battle_controller_if bus_a ();
  battle_controller_if bus_b ();

  battle_controller #(.ROUND_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  battle_controller #(.ROUND_CYCLES(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Stimulus shared by both controllers.
  logic        start;
  logic [15:0] tile, php, patk, pdef;
  logic [15:0] cur_tile, cur_eatk, cur_edef, cur_ehp;

  assign bus_a.start        = start;
  assign bus_a.enemy_tile   = tile;
  assign bus_a.player_hp_in = php;
  assign bus_a.player_atk   = patk;
  assign bus_a.player_def   = pdef;
  assign bus_b.start        = start;
  assign bus_b.enemy_tile   = tile;
  assign bus_b.player_hp_in = php;
  assign bus_b.player_atk   = patk;
  assign bus_b.player_def   = pdef;

  // Stat lookup: only the current enemy tile has stats, everything else reads 0.
  assign bus_a.enemy_atk_in = (bus_a.lookup_tile_id == cur_tile) ? cur_eatk : 16'd0;
  assign bus_a.enemy_def_in = (bus_a.lookup_tile_id == cur_tile) ? cur_edef : 16'd0;
  assign bus_a.enemy_hp_in  = (bus_a.lookup_tile_id == cur_tile) ? cur_ehp  : 16'd0;
  assign bus_b.enemy_atk_in = (bus_b.lookup_tile_id == cur_tile) ? cur_eatk : 16'd0;
  assign bus_b.enemy_def_in = (bus_b.lookup_tile_id == cur_tile) ? cur_edef : 16'd0;
  assign bus_b.enemy_hp_in  = (bus_b.lookup_tile_id == cur_tile) ? cur_ehp  : 16'd0;

  // Observed outputs, index 0 = R=1 instance, index 1 = R=4 instance.
  logic [1:0]  o_done, o_busy, o_strobe, o_side;
  logic [1:0]  o_res   [2];
  logic [15:0] o_php   [2];
  logic [15:0] o_ehp   [2];
  logic [15:0] o_tile  [2];
  logic [7:0]  o_round [2];
  assign o_done   = {bus_b.done, bus_a.done};
  assign o_busy   = {bus_b.busy, bus_a.busy};
  assign o_strobe = {bus_b.hit_strobe, bus_a.hit_strobe};
  assign o_side   = {bus_b.hit_side, bus_a.hit_side};
  assign o_res[0]   = bus_a.result;        assign o_res[1]   = bus_b.result;
  assign o_php[0]   = bus_a.player_hp_out; assign o_php[1]   = bus_b.player_hp_out;
  assign o_ehp[0]   = bus_a.enemy_hp_out;  assign o_ehp[1]   = bus_b.enemy_hp_out;
  assign o_tile[0]  = bus_a.lookup_tile_id; assign o_tile[1] = bus_b.lookup_tile_id;
  assign o_round[0] = bus_a.round_cnt;     assign o_round[1] = bus_b.round_cnt;

  int rc [2] = '{1, 4};
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference fight: plain turn-by-turn arithmetic on hit points.
  task automatic model(input int hp, input int atk, input int def, input int eatk,
                       input int edef, input int ehp, output int res, output int p_end,
                       output int e_end, output int strikes, output int rounds);
    int p, e, d;
    p = hp; e = ehp; strikes = 0; rounds = 0; res = 0;
    if (atk <= edef) res = 3;
    while (res == 0) begin
      d = atk - edef;
      strikes++; rounds++;
      if (d >= e) begin
        e = 0; res = 1;
      end else begin
        e = e - d;
        d = (eatk > def) ? eatk - def : 0;
        strikes++;
        if (d != 0 && d >= p) begin
          p = 0; res = 2;
        end else begin
          p = p - d;
        end
      end
    end
    if (rounds > 255) rounds = 255;
    p_end = p; e_end = e;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_busy"},   32'(o_busy[i]),   0);
      check({tag, "_done"},   32'(o_done[i]),   0);
      check({tag, "_result"}, 32'(o_res[i]),    0);
      check({tag, "_php"},    32'(o_php[i]),    0);
      check({tag, "_ehp"},    32'(o_ehp[i]),    0);
      check({tag, "_strobe"}, 32'(o_strobe[i]), 0);
      check({tag, "_side"},   32'(o_side[i]),   0);
      check({tag, "_round"},  32'(o_round[i]),  0);
      check({tag, "_tile"},   32'(o_tile[i]),   0);
    end
  endtask

  // Issue start at a falling edge; returns just after E0.
  task automatic launch(input int hp, input int atk, input int def, input int eatk,
                        input int edef, input int ehp, input logic [15:0] tl);
    @(negedge clk);
    cur_tile = tl; cur_eatk = 16'(eatk); cur_edef = 16'(edef); cur_ehp = 16'(ehp);
    tile = tl; php = 16'(hp); patk = 16'(atk); pdef = 16'(def);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Player stats must no longer matter once latched.
    php = 16'($urandom); patk = 16'($urandom); pdef = 16'($urandom);
  endtask

  task automatic run_fight(input string name, input int hp, input int atk, input int def,
                           input int eatk, input int edef, input int ehp,
                           input bit mid_start, input logic [15:0] tl);
    int res, p_end, e_end, strikes, rounds, n, last;
    int done_at [2];
    int done_cnt [2];
    int strobes [2];
    model(hp, atk, def, eatk, edef, ehp, res, p_end, e_end, strikes, rounds);
    launch(hp, atk, def, eatk, edef, ehp, tl);
    for (int i = 0; i < 2; i++) begin
      check({name, "_tile"}, 32'(o_tile[i]), 32'(tl));
      done_at[i] = -1; done_cnt[i] = 0; strobes[i] = 0;
    end
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < 2; i++) begin
        if (o_strobe[i]) begin
          check({name, "_side"}, 32'(o_side[i]), 32'(strobes[i] % 2));
          strobes[i]++;
        end
        if (o_done[i]) begin
          done_cnt[i]++;
          if (done_at[i] < 0) done_at[i] = n;
        end
      end
      start = (mid_start && n == 4 && o_busy == 2'b11) ? 1'b1 : 1'b0;
      if (done_at[0] >= 0 && done_at[1] >= 0) begin
        last = (done_at[0] > done_at[1]) ? done_at[0] : done_at[1];
        if (n == last + 1) break;
      end
      if (n > 3000) begin
        check({name, "_timeout"}, 1, 0);
        break;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check({name, "_result"},  32'(o_res[i]),   32'(res));
      check({name, "_php"},     32'(o_php[i]),   32'(p_end));
      check({name, "_ehp"},     32'(o_ehp[i]),   32'(e_end));
      check({name, "_round"},   32'(o_round[i]), 32'(rounds));
      check({name, "_strobes"}, 32'(strobes[i]), 32'(strikes));
      check({name, "_done_at"}, 32'(done_at[i]), 32'(2 + strikes * rc[i]));
      check({name, "_done_n"},  32'(done_cnt[i]), 1);
      check({name, "_busy_end"}, 32'(o_busy[i]), 0);
    end
  endtask

  initial begin
    int n_done;
    start = 1'b0; tile = '0; php = '0; patk = '0; pdef = '0;
    cur_tile = 16'h0101; cur_eatk = '0; cur_edef = '0; cur_ehp = '0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_fight("win",     100, 6, 3, 5, 2, 10, 1'b0, 16'h0101);
    run_fight("lose",      3, 6, 3, 5, 2, 10, 1'b0, 16'h0202);
    run_fight("refused",  50, 2, 3, 5, 2, 10, 1'b0, 16'h0303);
    run_fight("zero_dmg", 50, 4, 5, 1, 0, 12, 1'b0, 16'h0404);
    run_fight("mid_start",100, 6, 3, 5, 2, 10, 1'b1, 16'h0505);
    run_fight("zero_ehp", 20, 3, 1, 9, 1,  0, 1'b0, 16'h0606);

    // Reset while the R=1 instance sits in E_HIT after the first strike.
    launch(100, 6, 3, 5, 2, 10, 16'h0707);
    n_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done != 2'b00) n_done++;
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_done != 2'b00) n_done++;
    end
    check("mid_reset_no_done", 32'(n_done), 0);
    check("mid_reset_idle", 32'(o_busy), 0);
    run_fight("after_reset", 100, 6, 3, 5, 2, 10, 1'b0, 16'h0808);

    // Randomized fights.
    for (int k = 0; k < 20; k++) begin
      run_fight("rand",
                $urandom_range(1, 60), $urandom_range(1, 20), $urandom_range(0, 10),
                $urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 60),
                1'($urandom_range(0, 1)), 16'($urandom_range(1, 16'hFFFF)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
